// File: rtl/cacheline_burst_adaptor.sv
// cacheline_burst_adaptor: cache line <-> memory burst bridge; define CACHELINE_ADAPTOR_CWF_EN for critical-word-first reads
module cacheline_burst_adaptor #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);
  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFF_W) - 1);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  rd_slot;
  logic [LINE_W-1:0] buffer;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rd_addr;
  logic              last;
  assign last = cnt == CNT_W'(BEATS - 1);
`ifdef CACHELINE_ADAPTOR_CWF_EN
  localparam int BOFF_W = $clog2(BURST_W / 8);
  logic [CNT_W-1:0] start;
  assign rd_slot = start + cnt;
  assign rd_addr = address_i & ~ADDR_W'((1 << BOFF_W) - 1);
  always_ff @(posedge clk)
    if (reset) start <= '0;
    else if (state == IDLE && read_i) start <= address_i[OFF_W-1 -: CNT_W];
`else
  assign rd_slot = cnt;
  assign rd_addr = address_i & LINE_MASK;
`endif
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (read_i ? RD : write_i ? WR : IDLE)
              : state == DONE ? IDLE
              : (resp_i && last) ? DONE : state;
  always_ff @(posedge clk)
    if (reset) begin
      cnt    <= '0;
      buffer <= '0;
      addr_q <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
      if (read_i) addr_q <= rd_addr;
      else if (write_i) begin
        addr_q <= address_i & LINE_MASK;
        buffer <= line_i;
      end
    end else if (state == RD && resp_i) begin
      buffer[int'(rd_slot)*BURST_W +: BURST_W] <= burst_i;
      cnt <= cnt + CNT_W'(1);
    end else if (state == WR && resp_i)
      cnt <= cnt + CNT_W'(1);
  always_comb begin
    read_o    = state == RD;
    write_o   = state == WR;
    resp_o    = state == DONE;
    address_o = addr_q;
    line_o    = buffer;
    burst_o   = buffer[int'(cnt)*BURST_W +: BURST_W];
  end
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// tb_cacheline_burst_adaptor: randomized checks against a line/beat reference model
module tb_cacheline_burst_adaptor;
`ifdef CACHELINE_ADAPTOR_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  logic [255:0] line_i, line_o;
  logic [31:0] address_i, address_o;
  logic read_i, write_i, resp_o, read_o, write_o, resp_i;
  logic [63:0] burst_i, burst_o;
  logic [511:0] w_line_i, w_line_o;
  logic [31:0] w_address_i, w_address_o;
  logic w_read_i, w_write_i, w_resp_o, w_read_o, w_write_o, w_resp_i;
  logic [127:0] w_burst_i, w_burst_o;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  cacheline_burst_adaptor u_dut (
    .clk(clk), .reset(reset), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );
  cacheline_burst_adaptor #(.LINE_W(512), .BURST_W(128), .ADDR_W(32)) u_wide (
    .clk(clk), .reset(reset), .line_i(w_line_i), .line_o(w_line_o),
    .address_i(w_address_i), .read_i(w_read_i), .write_i(w_write_i), .resp_o(w_resp_o),
    .burst_i(w_burst_i), .burst_o(w_burst_o), .address_o(w_address_o),
    .read_o(w_read_o), .write_o(w_write_o), .resp_i(w_resp_i)
  );
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_read(input logic [31:0] a, input logic [63:0] base, input bit rnd,
                         input logic [15:0] pat, input int plen, input int stall, input bit both);
    logic [63:0] b [4];
    logic [255:0] exp_line;
    int k, n, start;
    start = CWF ? int'((a >> 3) % 4) : 0;
    exp_line = '0;
    for (int i = 0; i < 4; i++) begin
      b[i] = rnd ? {$urandom, $urandom} : base + 64'(i);
      exp_line[((start + i) % 4)*64 +: 64] = b[i];
    end
    read_i = 1'b1; write_i = both; address_i = a; line_i = {8{$urandom}};
    tick();
    read_i = 1'b0; write_i = 1'b0;
    chk("rd_addr", address_o, CWF ? (a & ~32'h7) : (a & ~32'h1f));
    k = 0; n = 0;
    while (k < 4 && n < 64) begin
      chk("rd_read_o", read_o, 1);
      chk("rd_write_o", write_o, 0);
      chk("rd_resp_early", resp_o, 0);
      resp_i = n < plen ? pat[n] : ($urandom_range(0, 99) >= stall);
      burst_i = resp_i ? b[k] : {$urandom, $urandom};
      tick();
      if (resp_i) k++;
      n++;
    end
    resp_i = 1'b0;
    chk("rd_beats", k, 4);
    chk("rd_resp_pulse", resp_o, 1);
    chk("rd_done_read_o", read_o, 0);
    chk("rd_done_line", line_o, exp_line);
    tick();
    chk("rd_resp_once", resp_o, 0);
    chk("rd_idle_read_o", read_o, 0);
    chk("rd_line", line_o, exp_line);
  endtask
  task automatic do_write(input logic [31:0] a, input logic [255:0] line,
                          input logic [15:0] pat, input int plen, input int stall);
    int k, n;
    write_i = 1'b1; address_i = a; line_i = line;
    tick();
    write_i = 1'b0; line_i = '0;
    chk("wr_addr", address_o, a & ~32'h1f);
    k = 0; n = 0;
    while (k < 4 && n < 64) begin
      chk("wr_write_o", write_o, 1);
      chk("wr_read_o", read_o, 0);
      chk("wr_resp_early", resp_o, 0);
      chk("wr_burst", burst_o, line[k*64 +: 64]);
      resp_i = n < plen ? pat[n] : ($urandom_range(0, 99) >= stall);
      tick();
      if (resp_i) k++;
      n++;
    end
    resp_i = 1'b0;
    chk("wr_beats", k, 4);
    chk("wr_resp_pulse", resp_o, 1);
    chk("wr_done_write_o", write_o, 0);
    tick();
    chk("wr_resp_once", resp_o, 0);
    chk("wr_line", line_o, line);
  endtask
  initial begin
    logic [31:0] wa;
    logic [127:0] wb [4];
    logic [511:0] w_exp;
    int k, n, ws;
    reset = 1'b1;
    {read_i, write_i, resp_i, w_read_i, w_write_i, w_resp_i} = '0;
    line_i = '0; address_i = '0; burst_i = '0;
    w_line_i = '0; w_address_i = '0; w_burst_i = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_read_o", read_o, 0);
    chk("rst_write_o", write_o, 0);
    chk("rst_resp_o", resp_o, 0);
    chk("rst_addr", address_o, 0);
    chk("rst_line", line_o, 0);
    chk("rst_burst", burst_o, 0);
    tick();
    chk("idle_resp_ignored", resp_o, 0);
    do_read(32'h0000_1234, 64'hAAAA_AAAA_AAAA_AAA0, 1'b0, 16'h0, 0, 0, 1'b0);
    do_write(32'h0000_4321, {64'hDDDD_DDDD_DDDD_DDD3, 64'hDDDD_DDDD_DDDD_DDD2,
             64'hDDDD_DDDD_DDDD_DDD1, 64'hDDDD_DDDD_DDDD_DDD0}, 16'h0039, 6, 0);
    do_read($urandom, 64'h0, 1'b1, 16'h0, 0, 20, 1'b1);
    read_i = 1'b1; address_i = $urandom;
    tick();
    read_i = 1'b0;
    resp_i = 1'b1; burst_i = {$urandom, $urandom};
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; resp_i = 1'b0;
    chk("abort_read_o", read_o, 0);
    chk("abort_resp_o", resp_o, 0);
    chk("abort_addr", address_o, 0);
    chk("abort_line", line_o, 0);
    tick();
    chk("abort_no_resp", resp_o, 0);
    chk("abort_idle_read_o", read_o, 0);
    do_read(32'h0000_1230, 64'hBBBB_BBBB_BBBB_BBB0, 1'b0, 16'h0, 0, 0, 1'b0);
    for (int t = 0; t < 24; t++)
      if ($urandom_range(0, 1) == 1)
        do_read($urandom, 64'h0, 1'b1, 16'h0, 0, 30, 1'($urandom_range(0, 1)));
      else
        do_write($urandom, {8{$urandom}}, 16'h0, 0, 30);
    wa = $urandom;
    ws = CWF ? int'((wa >> 4) % 4) : 0;
    w_exp = '0;
    for (int i = 0; i < 4; i++) begin
      wb[i] = {$urandom, $urandom, $urandom, $urandom};
      w_exp[((ws + i) % 4)*128 +: 128] = wb[i];
    end
    w_read_i = 1'b1; w_address_i = wa;
    tick();
    w_read_i = 1'b0;
    chk("w_addr", w_address_o, CWF ? (wa & ~32'hf) : (wa & ~32'h3f));
    k = 0; n = 0;
    while (k < 4 && n < 64) begin
      chk("w_read_o", w_read_o, 1);
      chk("w_resp_early", w_resp_o, 0);
      w_resp_i = $urandom_range(0, 99) >= 25;
      w_burst_i = w_resp_i ? wb[k] : '0;
      tick();
      if (w_resp_i) k++;
      n++;
    end
    w_resp_i = 1'b0;
    chk("w_beats", k, 4);
    chk("w_resp_pulse", w_resp_o, 1);
    tick();
    chk("w_resp_once", w_resp_o, 0);
    chk("w_line", w_line_o, w_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
- Parametrised bridge between the last-level cache (one full line per request) and the burst memory port (one BURST_W beat per resp_i cycle).
- Splits write lines into beats and assembles read beats into lines.
- Tolerates stalls between beats, line-aligns the memory address, and optionally returns the critical word first.

Parameters:
- LINE_W, 256, cache line width in bits.
- BURST_W, 64, memory beat width in bits. LINE_W/BURST_W = BEATS must be a power of 2 and at least 2.
- ADDR_W, 32, address width.
- Derived, not overridable: BEATS = LINE_W/BURST_W; CNT_W = $clog2(BEATS); OFF_W = $clog2(LINE_W/8).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- line_i  in  LINE_W  write line from the LLC.
- line_o  out  LINE_W  assembled read line.
- address_i  in  ADDR_W  LLC byte address.
- read_i  in  1  LLC read request.
- write_i  in  1  LLC write request.
- resp_o  out  1  one-cycle completion pulse to the LLC.
- burst_i  in  BURST_W  read beat from memory.
- burst_o  out  BURST_W  write beat to memory.
- address_o  out  ADDR_W  memory address.
- read_o  out  1  memory read request.
- write_o  out  1  memory write request.
- resp_i  in  1  beat-valid/accept from memory.

Behaviour:
- States: IDLE, RD, WR, DONE.
- Reset values:
  - State = IDLE; beat counter = 0.
  - Line buffer and address register = 0.
  - resp_o, read_o, write_o = 0; address_o = 0; line_o = 0; burst_o = 0.
- IDLE:
  - Samples read_i/write_i every cycle. Read has priority when both are high.
  - On read: capture address, counter <= 0, go to RD.
  - On write: capture address and line_i into the buffer, counter <= 0, go to WR.
  - resp_i in IDLE is ignored.
- address_o:
  - Equals the captured address with the low OFF_W bits cleared.
  - Stable for the whole transaction.
- RD:
  - read_o = 1 for every cycle in RD.
  - Each cycle with resp_i = 1: buffer[counter*BURST_W +: BURST_W] <= burst_i, counter += 1.
  - A cycle with resp_i = 0 is a stall: no buffer write, no counter change, read_o stays 1.
  - The beat accepted with counter == BEATS-1 moves to DONE.
- WR:
  - write_o = 1 for every cycle in WR.
  - burst_o = buffer[counter*BURST_W +: BURST_W] combinationally.
  - Each resp_i = 1 cycle consumes the current beat and advances the counter. Stalls hold the counter.
  - The last beat moves to DONE.
- DONE:
  - resp_o = 1 for exactly one cycle, then IDLE.
- line_o:
  - Always shows the buffer.
  - Valid for reads from the DONE cycle until the next transaction starts.
- Latency (resp_i high continuously):
  - Request seen in IDLE at cycle 0.
  - read_o/write_o high in cycles 1..BEATS.
  - resp_o in cycle BEATS+1; IDLE in cycle BEATS+2.
  - Each stall cycle adds one cycle.
- The LLC must drop read_i/write_i in the cycle after resp_o. A request still high in IDLE starts a new transaction.
- Counter wraps modulo BEATS; the counter never exceeds BEATS-1.
- Reset asserted mid-transaction:
  - Next cycle is IDLE with all outputs at reset values.
  - No resp_o for the aborted transaction.
  - Beats in flight are dropped.

Optional Feature:
- Macro: CACHELINE_ADAPTOR_CWF_EN.
- Defined (reads only):
  - start = address_i[OFF_W-1 -: CNT_W], captured at request.
  - address_o clears only the low $clog2(BURST_W/8) bits.
  - Read beat k writes buffer slot (start+k) mod BEATS. Completion still occurs after BEATS beats.
  - Writes are unchanged: line-aligned address, beat 0 first.
- Undefined:
  - All transfers start at beat 0 with a line-aligned address.
  - No start register.

Test Plan:
- Read, defaults, resp_i always 1, address_i=0x0000_1234, beats 0xA..A0 to 0xA..A3 -> address_o=0x0000_1220; read_o high 4 cycles; resp_o at cycle 5; line_o={A3,A2,A1,A0}.
- Write line_i={D3,D2,D1,D0}, resp_i pattern 1,0,0,1,1,1 -> burst_o shows D0, D1(held through 2 stalls), D1, D2, D3; write_o high 6 cycles; single resp_o pulse.
- read_i=write_i=1 in IDLE -> read transaction only; write_o never asserted.
- Reset asserted after 2 read beats -> next cycle IDLE, read_o=0, resp_o never pulses. Subsequent full read completes normally.
- LINE_W=512, BURST_W=128 read -> 4 beats of 128 bits; address_o low 6 bits cleared; resp_o after 4 accepted beats.
- CACHELINE_ADAPTOR_CWF_EN defined, read address_i=0x0000_1230 (start=2), beats B0..B3 -> address_o=0x0000_1230; line_o={B1,B0,B3,B2}.
